// File: rtl/rx_link_pkg.sv
// Shared types and constants for the GTP receive payload path:
// link FSM states, received-word classes and the IDLE pattern defaults.
package rx_link_pkg;

    typedef enum logic [1:0] {
        ST_LOS    = 2'd0,
        ST_ALIGN  = 2'd1,
        ST_LINKED = 2'd2
    } link_state_e;

    typedef enum logic [1:0] {
        WC_IDLE = 2'd0,
        WC_DATA = 2'd1,
        WC_ERR  = 2'd2
    } word_class_e;

    localparam logic [15:0] IDLE_WORD_DEF = 16'h50BC;  // K28.5 in the low byte
    localparam logic [1:0]  IDLE_K_DEF    = 2'b01;

    // A word is IDLE only with the exact K pattern and value; any K flag
    // that does not form an IDLE is a code error.
    function automatic word_class_e classify_word(
        input logic [15:0] data,
        input logic [1:0]  charisk,
        input logic [15:0] idle_word,
        input logic [1:0]  idle_k
    );
        word_class_e cls;
        if ((charisk == idle_k) && (data == idle_word)) begin
            cls = WC_IDLE;
        end else if (charisk == 2'b00) begin
            cls = WC_DATA;
        end else begin
            cls = WC_ERR;
        end
        return cls;
    endfunction

endpackage

// File: rtl/rx_seq_checker.sv
// Incrementing-counter checker for received payload words.
// The first word after link-up seeds the expected value; every later word,
// written or dropped, is compared and the expectation always resyncs to
// the received word plus one. The mismatch count saturates.
module rx_seq_checker (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clr,
    input  logic        i_vld,
    input  logic [15:0] i_data,
    output logic [15:0] o_err_cnt
);

    logic        r_seeded;
    logic [15:0] r_expected;
    logic [15:0] r_err_cnt;

    // Track expected value and count mismatches while linked
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seeded   <= 1'b0;
            r_expected <= 16'h0000;
            r_err_cnt  <= 16'h0000;
        end else if (i_clr) begin
            r_seeded <= 1'b0;
        end else if (i_vld) begin
            if (r_seeded && (i_data != r_expected) && (r_err_cnt != 16'hFFFF)) begin
                r_err_cnt <= r_err_cnt + 16'h0001;
            end
            r_expected <= i_data + 16'h0001;
            r_seeded   <= 1'b1;
        end
    end

    assign o_err_cnt = r_err_cnt;

endmodule

// File: rtl/rx_payload_extractor.sv
// Receive payload extractor: locks onto the IDLE stream from the GTP RX
// interface, strips IDLEs and writes payload words into the receive FIFO.
// Decisions are taken on the edge that samples a word and presented on
// the following edge, so every output lags its input word by one cycle.
// Optional sequence checker: define RX_SEQ_CHECK_EN.
module rx_payload_extractor
    import rx_link_pkg::*;
#(
    parameter logic [15:0] IDLE_WORD  = IDLE_WORD_DEF,
    parameter logic [1:0]  IDLE_K     = IDLE_K_DEF,
    parameter int unsigned LOCK_COUNT = 8,
    parameter int unsigned ERR_LIMIT  = 4
) (
    input  logic        rx_clk,
    input  logic        reset_n,
    input  logic        rxinit_done,
    input  logic [15:0] rx_data,
    input  logic [1:0]  rx_charisk,
    input  logic        fifo_full,
    output logic        fifo_wr_en,
    output logic [15:0] fifo_din,
    output logic        link_up,
    output logic        overflow,
    output logic [15:0] seq_err_cnt
);

    localparam logic [7:0] LOCK_LIM = 8'(LOCK_COUNT);
    localparam logic [3:0] ERR_LIM  = 4'(ERR_LIMIT);

    word_class_e w_class;
    link_state_e r_state, w_state_nxt;
    logic [7:0]  r_lock_cnt, w_lock_nxt;
    logic [3:0]  r_err_cnt, w_err_nxt;
    logic        w_wr, w_drop;
    logic        r_wr_s1, r_drop_s1;
    logic [15:0] r_din_s1;

    assign w_class = classify_word(rx_data, rx_charisk, IDLE_WORD, IDLE_K);

    // Link FSM and lock/error counters
    always_ff @(posedge rx_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_LOS;
            r_lock_cnt <= 8'd0;
            r_err_cnt  <= 4'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_lock_cnt <= w_lock_nxt;
            r_err_cnt  <= w_err_nxt;
        end
    end

    // Next-state, counter updates and write/drop decision for the sampled word
    always_comb begin
        w_state_nxt = r_state;
        w_lock_nxt  = r_lock_cnt;
        w_err_nxt   = r_err_cnt;
        w_wr        = 1'b0;
        w_drop      = 1'b0;
        if (!rxinit_done) begin
            w_state_nxt = ST_LOS;
            w_lock_nxt  = 8'd0;
            w_err_nxt   = 4'd0;
        end else begin
            case (r_state)
                ST_LOS: begin
                    w_state_nxt = ST_ALIGN;
                    w_lock_nxt  = 8'd0;
                    w_err_nxt   = 4'd0;
                end
                ST_ALIGN: begin
                    if (w_class == WC_IDLE) begin
                        if ((r_lock_cnt + 8'd1) == LOCK_LIM) begin
                            w_state_nxt = ST_LINKED;
                            w_lock_nxt  = 8'd0;
                            w_err_nxt   = 4'd0;
                        end else begin
                            w_lock_nxt = r_lock_cnt + 8'd1;
                        end
                    end else begin
                        w_lock_nxt = 8'd0;
                    end
                end
                ST_LINKED: begin
                    case (w_class)
                        WC_DATA: begin
                            w_err_nxt = 4'd0;
                            if (fifo_full) begin
                                w_drop = 1'b1;
                            end else begin
                                w_wr = 1'b1;
                            end
                        end
                        WC_IDLE: begin
                            w_err_nxt = 4'd0;
                        end
                        WC_ERR: begin
                            if ((r_err_cnt + 4'd1) == ERR_LIM) begin
                                w_state_nxt = ST_ALIGN;
                                w_lock_nxt  = 8'd0;
                                w_err_nxt   = 4'd0;
                            end else begin
                                w_err_nxt = r_err_cnt + 4'd1;
                            end
                        end
                        default: begin
                            w_err_nxt = r_err_cnt;
                        end
                    endcase
                end
                default: begin
                    w_state_nxt = ST_LOS;
                    w_lock_nxt  = 8'd0;
                    w_err_nxt   = 4'd0;
                end
            endcase
        end
    end

    // First pipeline stage: capture the decision made for the sampled word
    always_ff @(posedge rx_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_s1   <= 1'b0;
            r_drop_s1 <= 1'b0;
            r_din_s1  <= 16'h0000;
        end else begin
            r_wr_s1   <= w_wr;
            r_drop_s1 <= w_drop;
            r_din_s1  <= rx_data;
        end
    end

    // Output registers; fifo_din holds the last written word, overflow is sticky
    always_ff @(posedge rx_clk or negedge reset_n) begin
        if (!reset_n) begin
            fifo_wr_en <= 1'b0;
            fifo_din   <= 16'h0000;
            link_up    <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            fifo_wr_en <= r_wr_s1;
            if (r_wr_s1) begin
                fifo_din <= r_din_s1;
            end
            link_up  <= (r_state == ST_LINKED);
            overflow <= overflow | r_drop_s1;
        end
    end

`ifdef RX_SEQ_CHECK_EN
    logic w_seq_vld;
    logic w_seq_clr;

    // Every DATA word seen while linked is checked, dropped ones included
    assign w_seq_vld = rxinit_done && (r_state == ST_LINKED) && (w_class == WC_DATA);
    assign w_seq_clr = (r_state != ST_LINKED);

    rx_seq_checker u_seq_checker (
        .clk       (rx_clk),
        .rst_n     (reset_n),
        .i_clr     (w_seq_clr),
        .i_vld     (w_seq_vld),
        .i_data    (rx_data),
        .o_err_cnt (seq_err_cnt)
    );
`else
    assign seq_err_cnt = 16'h0000;
`endif

endmodule
